// File: rtl/game_pkg.sv
// Shared types for the seven-room dragon maze: room encoding and the
// direction characters used to script a game.
package game_pkg;

  typedef enum logic [2:0] {
    CAVE      = 3'd0,
    TUNNEL    = 3'd1,
    RIVER     = 3'd2,
    STASH     = 3'd3,
    DEN       = 3'd4,
    VICTORY   = 3'd5,
    GRAVEYARD = 3'd6
  } room_t;

  localparam byte CH_N    = "N";
  localparam byte CH_S    = "S";
  localparam byte CH_E    = "E";
  localparam byte CH_W    = "W";
  localparam byte CH_IDLE = "_";

endpackage

// File: rtl/game_sword.sv
// Sword flag: picked up on the first edge spent in the stash, kept until reset.
module game_sword (
  input  logic clock,
  input  logic reset_n,
  input  logic in_stash,
  output logic sword
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sword <= 1'b0;
    end else if (in_stash) begin
      sword <= 1'b1;
    end
  end

endmodule

// File: rtl/game.sv
// Room FSM for the dragon maze. One-hot direction strobes move the player;
// the Den resolves to Victory or Graveyard depending on the sword.
module game
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       n,
  input  logic       s,
  input  logic       e,
  input  logic       w,
  output logic       win,
  output logic       dead,
  output logic [2:0] room,
  output logic       sword
);

  room_t room_reg;
  room_t room_next;
  logic  move;

  assign move = $onehot({n, s, e, w});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      room_reg <= CAVE;
    end else begin
      room_reg <= room_next;
    end
  end

  always_comb begin
    room_next = room_reg;
    case (room_reg)
      CAVE: begin
        if (move && e) room_next = TUNNEL;
      end
      TUNNEL: begin
        if (move && s) room_next = RIVER;
        else if (move && w) room_next = CAVE;
      end
      RIVER: begin
        if (move && w) room_next = STASH;
        else if (move && n) room_next = TUNNEL;
        else if (move && e) room_next = DEN;
      end
      STASH: begin
        if (move && e) room_next = RIVER;
      end
      DEN:       room_next = sword ? VICTORY : GRAVEYARD;
      VICTORY:   room_next = VICTORY;
      GRAVEYARD: room_next = GRAVEYARD;
      // The unused code 7 falls back to the start of the maze.
      default:   room_next = CAVE;
    endcase
  end

  game_sword u_sword (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_stash (room_reg == STASH),
    .sword    (sword)
  );

  assign room = room_reg;
  assign win  = (room_reg == VICTORY);
  assign dead = (room_reg == GRAVEYARD);

endmodule

// File: tb/tb_game.sv
// Scoreboard bench for the dragon maze: scripted games from the test plan
// plus random games, checked against a table-driven map of the maze.
module tb_game;
  import game_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
  logic       win, dead, sword;
  logic [2:0] room;

  always #5 clock = ~clock;

  game dut (
    .clock   (clock),
    .reset_n (reset_n),
    .n       (n),
    .s       (s),
    .e       (e),
    .w       (w),
    .win     (win),
    .dead    (dead),
    .room    (room),
    .sword   (sword)
  );

  typedef struct {
    int    room;
    bit    sword;
    byte   ch;
    int    seq;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   seq_no = 0;

  // Maze map: rooms 0..6, directions N=0 S=1 E=2 W=3, 4 = no move.
  int   map_tab[7][5];
  int   m_room;
  bit   m_sword;

  function automatic void build_map();
    for (int r = 0; r < 7; r++)
      for (int d = 0; d < 5; d++)
        map_tab[r][d] = r;
    map_tab[0][2] = 1;
    map_tab[1][1] = 2;
    map_tab[1][3] = 0;
    map_tab[2][3] = 3;
    map_tab[2][0] = 1;
    map_tab[2][2] = 4;
    map_tab[3][2] = 2;
  endfunction

  function automatic int dir_of(byte c);
    case (c)
      CH_N:    return 0;
      CH_S:    return 1;
      CH_E:    return 2;
      CH_W:    return 3;
      default: return 4;
    endcase
  endfunction

  task automatic drive(byte c);
    n = (c == CH_N);
    s = (c == CH_S) || (c == "X");
    e = (c == CH_E) || (c == "X");
    w = (c == CH_W);
  endtask

  task automatic step(byte c);
    int nr;
    drive(c);
    @(posedge clock);
    if (m_room == 4)      nr = m_sword ? 5 : 6;
    else                  nr = map_tab[m_room][dir_of(c)];
    m_sword = m_sword || (m_room == 3);
    m_room  = nr;
    seq_no++;
    exp_q.push_back('{room: m_room, sword: m_sword, ch: c, seq: seq_no});
    #1;
  endtask

  task automatic run(string str);
    for (int i = 0; i < str.len(); i++) step(str[i]);
    drive(CH_IDLE);
  endtask

  task automatic check_reset_state(string tag);
    tests++;
    if (room !== 3'd0 || sword !== 1'b0 || win !== 1'b0 || dead !== 1'b0) begin
      fails++;
      $display("FAIL %s: room=%0d sword=%b win=%b dead=%b, required room=0 sword=0 win=0 dead=0",
               tag, room, sword, win, dead);
    end else begin
      $display("reset %s: room=0 sword=0 win=0 dead=0 ok", tag);
    end
  endtask

  task automatic drain();
    int budget = 8;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reset is asserted between edges so the check shows it acts without a clock.
  task automatic do_reset(string tag);
    drain();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state(tag);
    m_room  = 0;
    m_sword = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      tests++;
      if (room !== x.room[2:0] || sword !== x.sword ||
          win !== (x.room == 5) || dead !== (x.room == 6)) begin
        fails++;
        $display("FAIL move#%0d '%c': room=%0d sword=%b win=%b dead=%b, required room=%0d sword=%b win=%b dead=%b",
                 x.seq, x.ch, room, sword, win, dead,
                 x.room, x.sword, (x.room == 5), (x.room == 6));
      end else begin
        $display("move#%0d '%c': room=%0d sword=%b win=%b dead=%b ok",
                 x.seq, x.ch, room, sword, win, dead);
      end
    end
  end

  initial begin
    string alphabet;
    string game_str;
    build_map();
    m_room  = 0;
    m_sword = 1'b0;
    #1;
    check_reset_state("power-on");
    @(negedge clock);
    reset_n = 1'b1;

    run("ESE");
    run("_____");
    do_reset("after ESE");
    run("ESWEE");
    run("NSEWX");
    do_reset("after ESWEE");
    run("EWESNSE");
    run("_NSEW");
    do_reset("after EWESNSE");
    run("_E_S_W_E_E");
    run("__N");
    do_reset("after idle game");
    run("NXEXWXSSNWNE");
    run("ESWE");
    do_reset("mid-game in river with sword");

    alphabet = "NSEW_X";
    for (int g = 0; g < 30; g++) begin
      game_str = "";
      for (int i = 0; i < 25; i++) begin
        int k = $urandom_range(5);
        game_str = {game_str, string'(alphabet[k])};
      end
      run(game_str);
      do_reset($sformatf("random game %0d", g));
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
